// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// State codes, opcodes, select codes and the encoding legality check.
package ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'b000;
    localparam logic [2:0] S_DECODE = 3'b001;
    localparam logic [2:0] S_EXEC   = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB     = 3'b100;
    localparam logic [2:0] S_HALT   = 3'b101;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic op_legal(input logic [6:0] opc,
                                      input logic [2:0] f3);
        logic ok;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM: ok = 1'b1;
            OP_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b111);
            OP_STORE:  ok = (f3 < 3'b011);
            OP_BRANCH: ok = (f3[2:1] != 2'b01);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition resolver: funct3 plus comparator flags to taken/BrUn.
// Reserved funct3 codes resolve as not taken.
module branch_resolve
    import ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_breq,
    input  logic       i_brlt,
    output logic       o_taken,
    output logic       o_brun
);

    always_comb begin
        o_brun = (i_funct3 == F3_BLTU) || (i_funct3 == F3_BGEU);
        case (i_funct3)
            F3_BEQ:           o_taken = i_breq;
            F3_BNE:           o_taken = !i_breq;
            F3_BLT, F3_BLTU:  o_taken = i_brlt;
            F3_BGE, F3_BGEU:  o_taken = !i_brlt;
            default:          o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with memory handshake and timeout.
// Define ILLEGAL_TRAP_EN to halt on illegal encodings (adds illegal_insn).
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRW,
    output logic [2:0]       Size,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSel,
    output logic [2:0]       ImmSel,
    output logic             RegWEn,
    output logic             BrUn,
    output logic             ASel,
    output logic             BSel,
    output logic [1:0]       WBSel,
    output logic [CNT_W-1:0] instret,
    output logic             bus_err,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal_insn,
`endif
    output logic [2:0]       state_o
);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_ret;
    logic             r_err;
    logic [TO_W-1:0]  r_wait;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_rd_nz;
    logic       w_lui, w_aui, w_jal, w_jalr, w_br;
    logic       w_ld, w_st, w_iop, w_rop, w_nop;
    logic       w_illegal, w_taken, w_brun;
    logic       w_waiting, w_to_hit;
    logic       w_unused;

    logic [2:0] w_nxt;
    logic       w_req, w_rw, w_irw, w_pcw, w_pcs;
    logic       w_rwe, w_bu, w_asel, w_bsel;
    logic [2:0] w_size, w_imm;
    logic [1:0] w_wb;

    assign w_opc   = instr[6:0];
    assign w_f3    = instr[14:12];
    assign w_rd_nz = |instr[11:7];
    assign w_unused = &{1'b0, instr[31:15]};

    assign w_lui  = (w_opc == OP_LUI);
    assign w_aui  = (w_opc == OP_AUIPC);
    assign w_jal  = (w_opc == OP_JAL);
    assign w_jalr = (w_opc == OP_JALR);
    assign w_br   = (w_opc == OP_BRANCH);
    assign w_ld   = (w_opc == OP_LOAD);
    assign w_st   = (w_opc == OP_STORE);
    assign w_iop  = (w_opc == OP_OPIMM);
    assign w_rop  = (w_opc == OP_OP);
    assign w_nop  = (w_opc == OP_FENCE) || (w_opc == OP_SYSTEM);
    assign w_illegal = !op_legal(w_opc, w_f3);

    branch_resolve u_br (
        .i_funct3 (w_f3),
        .i_breq   (BrEq),
        .i_brlt   (BrLT),
        .o_taken  (w_taken),
        .o_brun   (w_brun)
    );

    assign w_waiting = w_req && !mem_ready;
    assign w_to_hit  = (MEM_TIMEOUT != 0) && w_waiting &&
                       (r_wait == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_nxt  = r_state;
        w_req  = 1'b0;
        w_rw   = 1'b0;
        w_size = 3'b000;
        w_irw  = 1'b0;
        w_pcw  = 1'b0;
        w_pcs  = 1'b0;
        w_imm  = IMM_I;
        w_rwe  = 1'b0;
        w_bu   = 1'b0;
        w_asel = 1'b0;
        w_bsel = 1'b0;
        w_wb   = WB_MEM;
        unique case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_irw = 1'b1;
                    w_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_st:          w_imm = IMM_S;
                    w_br:          w_imm = IMM_B;
                    w_jal:         w_imm = IMM_J;
                    w_lui | w_aui: w_imm = IMM_U;
                    default:       w_imm = IMM_I;
                endcase
                if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_nxt = S_HALT;
`else
                    w_pcw = 1'b1;
                    w_nxt = S_FETCH;
`endif
                end else if (w_nop) begin
                    w_pcw = 1'b1;
                    w_nxt = S_FETCH;
                end else begin
                    w_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_asel = w_br | w_jal | w_aui;
                w_bsel = w_iop | w_ld | w_st | w_jalr |
                         w_br | w_jal | w_aui;
                if (w_br) begin
                    w_pcw = 1'b1;
                    w_pcs = w_taken;
                    w_bu  = w_brun;
                    w_nxt = S_FETCH;
                end else if (w_ld | w_st) begin
                    w_nxt = S_MEM;
                end else begin
                    w_nxt = S_WB;
                end
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_rw   = w_st;
                w_size = w_f3;
                if (mem_ready) begin
                    w_pcw = w_st;
                    w_nxt = w_st ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_rwe = w_rd_nz;
                w_pcw = 1'b1;
                w_nxt = S_FETCH;
                if (w_jal | w_jalr) begin
                    w_wb  = WB_PC4;
                    w_pcs = 1'b1;
                end else if (w_ld) begin
                    w_wb = WB_MEM;
                end else if (w_lui) begin
                    w_wb = WB_IMM;
                end else begin
                    w_wb = WB_ALU;
                end
            end
            S_HALT: w_nxt = S_HALT;
            default: w_nxt = S_FETCH;
        endcase
        if (w_to_hit) w_nxt = S_HALT;
    end

    // Strobes are forced low while rst is high so a reset mid-access
    // cannot leave a partial register, PC or memory write behind.
    assign mem_req = w_req & ~rst;
    assign MemRW   = w_rw & ~rst;
    assign Size    = rst ? 3'b000 : w_size;
    assign IRWrite = w_irw & ~rst;
    assign PCWrite = w_pcw & ~rst;
    assign PCSel   = w_pcs & ~rst;
    assign ImmSel  = rst ? 3'b000 : w_imm;
    assign RegWEn  = w_rwe & ~rst;
    assign BrUn    = w_bu & ~rst;
    assign ASel    = w_asel & ~rst;
    assign BSel    = w_bsel & ~rst;
    assign WBSel   = rst ? 2'b00 : w_wb;
    assign instret = r_ret;
    assign bus_err = r_err;
    assign state_o = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ret   <= '0;
            r_err   <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_pcw) r_ret <= r_ret + CNT_W'(1);
            if (w_to_hit) r_err <= 1'b1;
            if (w_nxt != r_state &&
                (w_nxt == S_FETCH || w_nxt == S_MEM))
                r_wait <= '0;
            else if (w_waiting)
                r_wait <= r_wait + TO_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_ill;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ill <= 1'b0;
        else if (r_state == S_DECODE && w_illegal)
            r_ill <= 1'b1;
    end
    assign illegal_insn = r_ill;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: vector table, random model, corners.
// Builds with or without ILLEGAL_TRAP_EN.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = '0;
    logic          BrEq = 1'b0;
    logic          BrLT = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, MemRW, IRWrite, PCWrite, PCSel;
    logic          RegWEn, BrUn, ASel, BSel, bus_err;
    logic [2:0]    Size, ImmSel, state_o;
    logic [1:0]    WBSel;
    logic [CW-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
    logic          illegal_insn;
`endif

    multicycle_control #(
        .CNT_W(CW), .MEM_TIMEOUT(5), .TO_W(8)
    ) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRW(MemRW), .Size(Size),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
        .ImmSel(ImmSel), .RegWEn(RegWEn), .BrUn(BrUn),
        .ASel(ASel), .BSel(BSel), .WBSel(WBSel),
        .instret(instret), .bus_err(bus_err),
`ifdef ILLEGAL_TRAP_EN
        .illegal_insn(illegal_insn),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, rw;
        logic [2:0] size;
        logic       irw, pcw, pcs;
        logic [2:0] imm;
        logic       rwe, brun, asel, bsel;
        logic [1:0] wb;
    } outs_t;

    typedef struct packed {
        logic  rdy;
        outs_t o;
    } cyc_t;

    typedef struct {
        logic [31:0] ins;
        logic        eq, lt;
        int          fw, mw, ncyc;
        logic        pcs, rwe, brun;
        logic [1:0]  wb;
    } vec_t;

    outs_t act;
    assign act = {state_o, mem_req, MemRW, Size, IRWrite, PCWrite,
                  PCSel, ImmSel, RegWEn, BrUn, ASel, BSel, WBSel};

    int checks = 0;
    int failures = 0;
    logic [CW-1:0] exp_ret = '0;
    cyc_t q[$];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic push(input logic r, input outs_t o);
        cyc_t c;
        c.rdy = r;
        c.o = o;
        q.push_back(c);
    endtask

    // Expected per-cycle outputs for one instruction, from the ISA rules.
    task automatic plan(input logic [31:0] ins, input logic eq,
                        input logic lt, input int fw, input int mw);
        outs_t o;
        logic [6:0] opc;
        logic [2:0] f3;
        logic br, ld, st, jal, jalr, lui, aui, rop, nop, tk;
        opc  = ins[6:0];
        f3   = ins[14:12];
        br   = opc == 7'h63;
        ld   = opc == 7'h03;
        st   = opc == 7'h23;
        jal  = opc == 7'h6f;
        jalr = opc == 7'h67;
        lui  = opc == 7'h37;
        aui  = opc == 7'h17;
        rop  = opc == 7'h33;
        nop  = opc == 7'h0f || opc == 7'h73;
        for (int i = 0; i < fw; i++) begin
            o = '0; o.req = 1'b1;
            push(1'b0, o);
        end
        o = '0; o.req = 1'b1; o.irw = 1'b1;
        push(1'b1, o);
        o = '0; o.st = 3'd1;
        o.imm = st ? 3'd1 : br ? 3'd2 : jal ? 3'd3 :
                (lui || aui) ? 3'd4 : 3'd0;
        o.pcw = nop;
        push(1'b0, o);
        if (nop) return;
        o = '0; o.st = 3'd2;
        o.asel = br || jal || aui;
        o.bsel = !(rop || lui);
        if (br) begin
            case (f3)
                3'd0: tk = eq;
                3'd1: tk = !eq;
                3'd4, 3'd6: tk = lt;
                default: tk = !lt;
            endcase
            o.pcw = 1'b1; o.pcs = tk; o.brun = (f3 >= 3'd6);
            push(1'b0, o);
            return;
        end
        push(1'b0, o);
        if (ld || st) begin
            o = '0; o.st = 3'd3; o.req = 1'b1; o.rw = st; o.size = f3;
            for (int i = 0; i < mw; i++) push(1'b0, o);
            o.pcw = st;
            push(1'b1, o);
            if (st) return;
        end
        o = '0; o.st = 3'd4; o.pcw = 1'b1;
        o.rwe = ins[11:7] != 5'd0;
        o.pcs = jal || jalr;
        o.wb = (jal || jalr) ? 2'd2 : ld ? 2'd0 : lui ? 2'd3 : 2'd1;
        push(1'b0, o);
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            mem_ready = c.rdy;
            #1;
            chk("cycle", 32'(act), 32'(c.o));
        end
        @(posedge clk);
        #1;
        exp_ret = exp_ret + 1'b1;
        chk("instret", 32'(instret), 32'(exp_ret));
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        logic [2:0] lf3 [5];
        logic [2:0] bf3 [6];
        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r = $urandom;
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: begin r[6:0] = 7'h03; r[14:12] = lf3[$urandom_range(0, 4)]; end
            3: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
            4: begin r[6:0] = 7'h63; r[14:12] = bf3[$urandom_range(0, 5)]; end
            5: r[6:0] = 7'h6f;
            6: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17;
            9: r[6:0] = 7'h0f;
            default: r[6:0] = 7'h73;
        endcase
        return r;
    endfunction

    vec_t tab [11];

    initial begin
        int nf, nm, n;
        logic got, c_pcs, c_rwe, c_brun;
        logic [1:0] c_wb;
        tab[0]  = '{32'h002081B3, 0, 0, 0, 0, 4, 0, 1, 0, 2'b01};
        tab[1]  = '{32'h0000A283, 0, 0, 0, 3, 8, 0, 1, 0, 2'b00};
        tab[2]  = '{32'h0020E063, 0, 1, 0, 0, 3, 1, 0, 1, 2'b00};
        tab[3]  = '{32'h0020D063, 0, 1, 0, 0, 3, 0, 0, 0, 2'b00};
        tab[4]  = '{32'h000000EF, 0, 0, 0, 0, 4, 1, 1, 0, 2'b10};
        tab[5]  = '{32'h0020A023, 0, 0, 2, 1, 7, 0, 0, 0, 2'b00};
        tab[6]  = '{32'h00000013, 0, 0, 1, 0, 5, 0, 0, 0, 2'b01};
        tab[7]  = '{32'h000003B7, 0, 0, 0, 0, 4, 0, 1, 0, 2'b11};
        tab[8]  = '{32'h0000000F, 0, 0, 0, 0, 2, 0, 0, 0, 2'b00};
        tab[9]  = '{32'h00208063, 1, 0, 0, 0, 3, 1, 0, 0, 2'b00};
        tab[10] = '{32'h000080E7, 0, 0, 0, 0, 4, 1, 1, 0, 2'b10};

        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            instr = tab[i].ins; BrEq = tab[i].eq; BrLT = tab[i].lt;
            nf = 0; nm = 0; n = 0; got = 1'b0;
            c_pcs = 0; c_rwe = 0; c_brun = 0; c_wb = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                mem_ready = 1'b0;
                if (state_o == 3'd0) begin
                    if (nf >= tab[i].fw) mem_ready = 1'b1; else nf++;
                end
                if (state_o == 3'd3) begin
                    if (nm >= tab[i].mw) mem_ready = 1'b1; else nm++;
                end
                #1;
                n++;
                if (PCWrite) begin
                    got = 1'b1; c_pcs = PCSel; c_rwe = RegWEn;
                    c_brun = BrUn; c_wb = WBSel;
                end
            end
            chk("tab_retired", 32'(got), 32'd1);
            chk("tab_cycles", n, tab[i].ncyc);
            chk("tab_PCSel", 32'(c_pcs), 32'(tab[i].pcs));
            chk("tab_RegWEn", 32'(c_rwe), 32'(tab[i].rwe));
            chk("tab_BrUn", 32'(c_brun), 32'(tab[i].brun));
            chk("tab_WBSel", 32'(c_wb), 32'(tab[i].wb));
            @(posedge clk);
            #1;
            exp_ret = exp_ret + 1'b1;
            chk("tab_instret", 32'(instret), 32'(exp_ret));
        end

        for (int r = 0; r < 40; r++) begin
            logic [31:0] ri;
            logic e, l;
            ri = rand_ins();
            e = 1'($urandom);
            l = 1'($urandom);
            plan(ri, e, l, $urandom_range(0, 3), $urandom_range(0, 3));
            instr = ri; BrEq = e; BrLT = l;
            run_q();
        end

        // reset while a load waits in MEM
        instr = 32'h0000A283;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("memwait_state", 32'(state_o), 32'd3);
        chk("memwait_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmem_req", 32'(mem_req), 32'd0);
        chk("rstmem_state", 32'(state_o), 32'd0);
        chk("rstmem_pcw", 32'(PCWrite), 32'd0);
        chk("rstmem_rwe", 32'(RegWEn), 32'd0);
        chk("rstmem_instret", 32'(instret), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;

        // opcode 0000000
        instr = 32'h00000000;
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        #1;
        chk("ill_decode", 32'(state_o), 32'd1);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_pcw", 32'(PCWrite), 32'd0);
        @(posedge clk);
        #1;
        chk("ill_halt", 32'(state_o), 32'd5);
        chk("ill_flag", 32'(illegal_insn), 32'd1);
        chk("ill_req", 32'(mem_req), 32'd0);
        chk("ill_instret", 32'(instret), 32'(exp_ret));
`else
        chk("ill_pcw", 32'(PCWrite), 32'd1);
        @(posedge clk);
        #1;
        exp_ret = exp_ret + 1'b1;
        chk("ill_fetch", 32'(state_o), 32'd0);
        chk("ill_instret", 32'(instret), 32'(exp_ret));
`endif

        // fetch timeout
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("to_pre_state", 32'(state_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k < 5) begin
                chk("to_wait_state", 32'(state_o), 32'd0);
                chk("to_wait_err", 32'(bus_err), 32'd0);
            end else begin
                chk("to_halt_state", 32'(state_o), 32'd5);
                chk("to_bus_err", 32'(bus_err), 32'd1);
                chk("to_halt_req", 32'(mem_req), 32'd0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("to_rst_state", 32'(state_o), 32'd0);
        chk("to_rst_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("to_refetch_req", 32'(mem_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder. It drives the same datapath select signals (PCSel, ImmSel, RegWEn, BrUn, BSel, ASel, MemRW, WBSel, Size), sequenced over FETCH/DECODE/EXEC/MEM/WB states.
- Adds a req/ready memory handshake, explicit PC and IR write enables, a retired-instruction counter and a memory-wait timeout.
- Sits between the instruction register/branch comparator and the shared-memory datapath of the multi-cycle core.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 0, maximum cycles to wait for mem_ready; 0 disables the timeout.
- TO_W, 8, width of the wait counter; must satisfy MEM_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- BrEq  in  1  comparator equal flag.
- BrLT  in  1  comparator less-than flag, signed or unsigned per BrUn.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- MemRW  out  1  1 = write, 0 = read.
- Size  out  3  access size, equal to funct3 of load/store; 000 during fetch.
- IRWrite  out  1  capture instruction into the IR.
- PCWrite  out  1  update the PC.
- PCSel  out  1  0 = PC+4, 1 = ALU result.
- ImmSel  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- RegWEn  out  1  register-file write enable.
- BrUn  out  1  unsigned compare.
- ASel  out  1  1 = PC as ALU operand A.
- BSel  out  1  1 = immediate as ALU operand B.
- WBSel  out  2  00 mem, 01 ALU, 10 PC+4, 11 immediate (LUI).
- instret  out  CNT_W  retired-instruction count.
- bus_err  out  1  sticky memory-timeout flag.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset, asynchronous: state = FETCH, instret = 0, bus_err = 0, wait counter = 0.
- All outputs are combinational from state and instr. Every output not listed for a state is 0 in that state.
- FETCH: mem_req = 1, MemRW = 0. Holds until mem_ready, then IRWrite = 1 and the next state is DECODE.
- DECODE: one cycle.
  - Classifies the opcode and sets ImmSel as in the single-cycle decoder.
  - FENCE (0001111) and SYSTEM (1110011) act as NOPs: PCWrite = 1, PCSel = 0, instret++, next state FETCH.
  - All other legal opcodes go to EXEC.
- EXEC: drives ASel/BSel per class:
  - R-type: 00.
  - I-ALU, load, store, JALR: 01.
  - Branch, JAL, AUIPC: 11.
  - LUI: don't-care.
- EXEC branch handling:
  - Taken is evaluated from funct3: 000 BrEq, 001 !BrEq, 100/110 BrLT, 101/111 !BrLT.
  - BrUn = 1 for funct3 110 and 111.
  - PCWrite = 1, PCSel = taken, instret++, next state FETCH.
- EXEC next state for other classes: load/store go to MEM; R, I-ALU, JAL, JALR, LUI and AUIPC go to WB.
- MEM: mem_req = 1, MemRW = 1 for store, Size = funct3. Holds until mem_ready.
  - Load then goes to WB.
  - Store asserts PCWrite = 1, PCSel = 0, instret++, and goes to FETCH.
- WB: RegWEn = 1 (suppressed when rd = 0), PCWrite = 1, instret++, next state FETCH.
  - JAL/JALR: WBSel = 10, PCSel = 1; JALR clears ALU bit 0 in the datapath.
  - Other classes: PCSel = 0.
- Wait counter: resets on entry to FETCH or MEM and increments while mem_req is high and !mem_ready.
- Timeout: if MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT, set bus_err and enter HALT.
- HALT: all outputs 0. Left only by reset.
- instret wraps modulo 2**CNT_W.
- mem_ready is ignored outside FETCH and MEM.
- Reset during a memory wait drops mem_req asynchronously. No partial register or PC write occurs.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal opcode, load funct3 011/111, store funct3 > 010, or branch funct3 010/011 detected in DECODE goes to HALT.
  - HALT asserts the extra output illegal_insn = 1, sticky until reset. instret is not incremented.
- Undefined: illegal encodings retire as NOPs (DECODE → FETCH with PCWrite and instret++), and the illegal_insn port is absent.

Decomposition:
- Package ctrl_pkg holds:
  - State encodings: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 101.
  - Opcode constants.
  - ImmSel and WBSel codes.
- One sub-module, branch_resolve: combinational funct3 + BrEq/BrLT → taken and BrUn.

Test Plan:
1. ADD x3,x1,x2 with mem_ready = 1 each request → states FETCH, DECODE, EXEC, WB over 4 cycles; RegWEn = 1 in WB; instret = 1.
2. LW with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles, Size = 010, WBSel = 00 in WB; total 8 cycles.
3. BLTU with BrLT = 1, then BGE with BrLT = 1 → first: PCSel = 1, BrUn = 1; second: PCSel = 0, BrUn = 0. Both assert PCWrite in EXEC.
4. JAL rd = x1 → WB: WBSel = 10, RegWEn = 1, PCSel = 1, PCWrite = 1.
5. MEM_TIMEOUT = 5, mem_ready held 0 in FETCH → bus_err set after 5 cycles, state HALT; asserting rst returns to FETCH with bus_err = 0.
6. Opcode 0000000 → with ILLEGAL_TRAP_EN: HALT and illegal_insn = 1. Without it: PCWrite = 1 in DECODE, instret increments.
